// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
package fwd_pkg;

  // Widest register index a tag entry can carry; narrower indices are zero-extended.
  localparam int MAX_REG_W = 8;

  // EX operand / store-data select encoding.
  localparam logic [1:0] FWD_RF  = 2'b00;  // value read from the register file
  localparam logic [1:0] FWD_MEM = 2'b01;  // EX/MEM pipeline result
  localparam logic [1:0] FWD_WB  = 2'b10;  // MEM/WB pipeline result

  // One destination-tag entry travelling down the pipeline.
  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] rd;
    logic                 we;
    logic                 is_load;
  } tag_entry_t;

  localparam tag_entry_t TAG_BUBBLE = '0;

endpackage

// File: rtl/fwd_tag_stage.sv
// One registered tag entry: kill inserts a bubble, load_en captures the incoming entry.
import fwd_pkg::*;

module fwd_tag_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  logic       kill,
  input  tag_entry_t entry_in,
  output tag_entry_t entry_out
);

  tag_entry_t entry_d;
  tag_entry_t entry_q;

  // Next entry: kill takes priority over a normal load; otherwise hold.
  always_comb begin
    entry_d = entry_q;
    if (kill) begin
      entry_d = TAG_BUBBLE;
    end else if (load_en) begin
      entry_d = entry_in;
    end
  end

  // Entry register, cleared to a bubble on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= TAG_BUBBLE;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_out = entry_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generation from a private EX/MEM/WB tag pipeline.
import fwd_pkg::*;

module fwd_hazard_unit #(
  parameter int REG_W    = 4,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_re_a,
  input  logic             id_re_b,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             id_is_store,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_st,
  output logic [CNT_W-1:0] stall_cnt
);

  tag_entry_t ex_q, mem_q, wb_q;
  tag_entry_t id_entry;
  logic [MAX_REG_W-1:0] ra_x, rb_x, rs_x;
  logic ex_load;
  logic ex_kill;

  logic [1:0]       fwd_a_d, fwd_a_q;
  logic [1:0]       fwd_b_d, fwd_b_q;
  logic [1:0]       fwd_st_d, fwd_st_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  // An entry produces register r if it is live, writes, and r is not the hardwired zero.
  function automatic logic tag_match(input tag_entry_t e, input logic [MAX_REG_W-1:0] r);
    tag_match = e.valid && e.we && (e.rd == r) && !((ZERO_REG != 0) && (r == '0));
  endfunction

  // The younger producer (currently in EX, in MEM next cycle) wins over the older one.
  // WB is never consulted: the register file is write-first.
  function automatic logic [1:0] fwd_sel(input logic [MAX_REG_W-1:0] r,
                                         input tag_entry_t ex_e, input tag_entry_t mem_e);
    if (tag_match(ex_e, r)) begin
      fwd_sel = FWD_MEM;
    end else if (tag_match(mem_e, r)) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_RF;
    end
  endfunction

  // Zero-extend the ID register fields to tag width and build the ID tag entry.
  always_comb begin
    ra_x = '0;
    rb_x = '0;
    rs_x = '0;
    ra_x[REG_W-1:0] = id_ra;
    rb_x[REG_W-1:0] = id_rb;
    rs_x[REG_W-1:0] = id_rs;
    id_entry = TAG_BUBBLE;
    id_entry.valid = 1'b1;
    id_entry.rd[REG_W-1:0] = id_rd;
    id_entry.we = id_we;
    id_entry.is_load = id_is_load;
  end

  // Load-use stall: only a load sitting in EX can be too late to forward; flush overrides.
  always_comb begin
    stall = id_valid && !flush && ex_q.is_load &&
            ((tag_match(ex_q, ra_x) && id_re_a) ||
             (tag_match(ex_q, rb_x) && id_re_b) ||
             (tag_match(ex_q, rs_x) && id_is_store));
  end

  assign ex_load = id_valid && !stall && !flush;
  assign ex_kill = !ex_load;

  // EX takes the ID instruction or a bubble every cycle.
  fwd_tag_stage u_ex_stage (
    .clk       (clk),
    .rst       (rst),
    .load_en   (1'b1),
    .kill      (ex_kill),
    .entry_in  (id_entry),
    .entry_out (ex_q)
  );

  // A flush kills the instruction leaving EX, so it never reaches MEM.
  fwd_tag_stage u_mem_stage (
    .clk       (clk),
    .rst       (rst),
    .load_en   (1'b1),
    .kill      (flush),
    .entry_in  (ex_q),
    .entry_out (mem_q)
  );

  fwd_tag_stage u_wb_stage (
    .clk       (clk),
    .rst       (rst),
    .load_en   (1'b1),
    .kill      (1'b0),
    .entry_in  (mem_q),
    .entry_out (wb_q)
  );

  // WB and MEM load flag are tracked for pipeline completeness but drive no select.
  logic unused_tags;
  assign unused_tags = ^{wb_q, mem_q.is_load};

  // Selects for the instruction entering EX; a bubble carries register-file selects.
  always_comb begin
    fwd_a_d  = FWD_RF;
    fwd_b_d  = FWD_RF;
    fwd_st_d = FWD_RF;
    if (ex_load) begin
      if (id_re_a)     fwd_a_d  = fwd_sel(ra_x, ex_q, mem_q);
      if (id_re_b)     fwd_b_d  = fwd_sel(rb_x, ex_q, mem_q);
      if (id_is_store) fwd_st_d = fwd_sel(rs_x, ex_q, mem_q);
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Select and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      fwd_st_q    <= FWD_RF;
      stall_cnt_q <= '0;
    end else begin
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      fwd_st_q    <= fwd_st_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign fwd_st    = fwd_st_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: each driven cycle pushes its hand-computed expectation; a negedge monitor checks.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_ra, id_rb, id_rs, id_rd;
  logic       id_re_a, id_re_b, id_we, id_is_load, id_is_store;
  logic       flush;

  logic       stall, z_stall;
  logic [1:0] fwd_a, fwd_b, fwd_st;
  logic [1:0] z_fwd_a, z_fwd_b, z_fwd_st;
  logic [3:0] stall_cnt, z_stall_cnt;

  typedef struct {
    logic       stall;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] st;
    logic [3:0] cnt;
    logic [1:0] a_z0;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  fwd_hazard_unit #(.REG_W(4), .ZERO_REG(1), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_ra(id_ra), .id_rb(id_rb), .id_rs(id_rs),
    .id_re_a(id_re_a), .id_re_b(id_re_b), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_is_store(id_is_store), .flush(flush),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_st(fwd_st),
    .stall_cnt(stall_cnt)
  );

  // Same stimulus, register 0 not hardwired.
  fwd_hazard_unit #(.REG_W(4), .ZERO_REG(0), .CNT_W(4)) u_dut_z0 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_ra(id_ra), .id_rb(id_rb), .id_rs(id_rs),
    .id_re_a(id_re_a), .id_re_b(id_re_b), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_is_store(id_is_store), .flush(flush),
    .stall(z_stall), .fwd_a(z_fwd_a), .fwd_b(z_fwd_b), .fwd_st(z_fwd_st),
    .stall_cnt(z_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall",     int'(stall),     int'(e.stall));
      check("fwd_a",     int'(fwd_a),     int'(e.a));
      check("fwd_b",     int'(fwd_b),     int'(e.b));
      check("fwd_st",    int'(fwd_st),    int'(e.st));
      check("stall_cnt", int'(stall_cnt), int'(e.cnt));
      check("z0_fwd_a",  int'(z_fwd_a),   int'(e.a_z0));
      $display("cycle t=%0t stall=%0d a=%0d b=%0d st=%0d cnt=%0d z0a=%0d",
               $time, stall, fwd_a, fwd_b, fwd_st, stall_cnt, z_fwd_a);
    end
  end

  // Drive one ID cycle and queue what must be seen during that cycle.
  task automatic cyc(input logic v, input int ra, input int rb, input int rs,
                     input logic rea, input logic reb, input int rd, input logic we,
                     input logic ld, input logic st, input logic fl, input logic rs_in,
                     input logic e_stall, input int e_a, input int e_b, input int e_st,
                     input int e_cnt, input int e_a0);
    exp_t e;
    id_valid = v;   id_ra = 4'(ra); id_rb = 4'(rb); id_rs = 4'(rs);
    id_re_a = rea;  id_re_b = reb;  id_rd = 4'(rd); id_we = we;
    id_is_load = ld; id_is_store = st; flush = fl; rst = rs_in;
    e.stall = e_stall; e.a = 2'(e_a); e.b = 2'(e_b); e.st = 2'(e_st);
    e.cnt = 4'(e_cnt); e.a_z0 = 2'(e_a0);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic rs_in, input int e_a, input int e_b, input int e_st,
                     input int e_cnt, input int e_a0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rs_in, 0, e_a, e_b, e_st, e_cnt, e_a0);
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_ra = 0; id_rb = 0; id_rs = 0; id_rd = 0;
    id_re_a = 0; id_re_b = 0; id_we = 0; id_is_load = 0; id_is_store = 0; flush = 0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    nop(0, 0, 0, 0, 0, 0);
    // ADD R1,R2,R3 ; SUB R4,R1,R5 -> fwd_a=01
    cyc(1, 2, 3, 0, 1, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 0, 1, 1, 4, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    nop(0, 1, 0, 0, 0, 1);
    // ADD R1 ; NOP ; ST data R1 (rb=R1 but not read) -> fwd_st=10, fwd_b=00
    cyc(1, 2, 3, 0, 1, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    nop(0, 0, 0, 0, 0, 0);
    cyc(1, 3, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    nop(0, 0, 0, 2, 0, 0);
    // LD R6 ; ADD R7,R6,R6 -> one stall, then 10/10
    cyc(1, 2, 0, 0, 1, 0, 6, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    cyc(1, 6, 6, 0, 1, 1, 7, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    cyc(1, 6, 6, 0, 1, 1, 7, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    nop(0, 2, 2, 0, 1, 2);
    // ADD R0 ; read R0 -> 00 with hardwired zero, 01 without
    cyc(1, 1, 2, 0, 1, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 8, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    nop(0, 0, 0, 0, 1, 1);
    // LD R2 in EX, consumer in ID with flush -> no stall; load killed, no 10 afterwards
    cyc(1, 3, 0, 0, 1, 0, 2, 1, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    cyc(1, 2, 2, 0, 1, 1, 9, 1, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0);
    cyc(1, 2, 0, 0, 1, 0, 9, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    nop(0, 0, 0, 0, 1, 0);
    // reset during a load-use stall -> stall drops, counter clears
    cyc(1, 1, 0, 0, 1, 0, 5, 1, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    cyc(1, 5, 0, 0, 1, 0, 10, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    cyc(1, 5, 0, 0, 1, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(0, 0, 0, 0, 0, 0);
    // 2**4+3 load-use stalls -> counter saturates at 15
    for (int k = 0; k < 19; k++) begin
      int pa;
      pa = (k == 0) ? 0 : 2;
      cyc(1, 1, 0, 0, 1, 0, 6, 1, 1, 0, 0, 0, 0, pa, pa, 0, (k < 15) ? k : 15, pa);
      cyc(1, 6, 6, 0, 1, 1, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0, (k < 15) ? k : 15, 0);
      cyc(1, 6, 6, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, (k + 1 < 15) ? k + 1 : 15, 0);
    end
    // reset pulse -> counter and selects return to zero next cycle
    nop(1, 2, 2, 0, 15, 2);
    nop(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
